// File: rtl/aioc_pe_pkg.sv
// Shared constants and types for the PE-array psum datapath.
package aioc_pe_pkg;

  localparam int unsigned ROW_NUM   = 32;
  localparam int unsigned PSUM_W    = 16;
  localparam int unsigned GLB_W     = 32;
  localparam int unsigned ROW_IDX_W = $clog2(ROW_NUM);

  typedef logic [PSUM_W-1:0]    psum_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;

endpackage

// File: rtl/ipsum_stream_buffer_if.sv
// GLB-to-buffer beat stream and buffer-to-Reducer drain bus.
interface ipsum_stream_buffer_if #(
  parameter int unsigned ROWS   = aioc_pe_pkg::ROW_NUM,
  parameter int unsigned PSUM_W = aioc_pe_pkg::PSUM_W,
  parameter int unsigned BUS_W  = aioc_pe_pkg::GLB_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [BUS_W-1:0]         in_data;
  logic                     drain;
  logic                     out_valid;
  logic [ROWS*PSUM_W-1:0]   out_data;
  logic [ROWS-1:0]          out_row_mask;
  logic                     fill_done;

  // Producer / consumer side (GLB + Reducer)
  modport master (
    output in_valid, in_data, drain,
    input  in_ready, out_valid, out_data, out_row_mask, fill_done
  );

  // Buffer side
  modport slave (
    input  in_valid, in_data, drain,
    output in_ready, out_valid, out_data, out_row_mask, fill_done
  );

endinterface

// File: rtl/ipsum_stream_buffer_row_fifo.sv
// Per-row psum FIFO: PER_BEAT-wide push, single pop, head always at slot 0.
module ipsum_row_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PSUM_W   = 16,
  parameter int unsigned PER_BEAT = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [PER_BEAT*PSUM_W-1:0]     push_data,
  input  logic                           pop,
  output logic [PSUM_W-1:0]              head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PSUM_W-1:0] mem_q [DEPTH];
  logic [PSUM_W-1:0] mem_d [DEPTH];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [CW-1:0]     base_c;

  // Shift on pop, then append the beat (oldest slice first) behind the survivors
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    base_c  = pop ? (count_q - CW'(1)) : count_q;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) mem_d[i] = mem_q[i+1];
        mem_d[DEPTH-1] = '0;
        count_d = count_d - CW'(1);
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          for (int j = 0; j < int'(PER_BEAT); j++) begin
            if (i == int'(base_c) + j)
              mem_d[i] = push_data[(int'(PER_BEAT) - 1 - j) * int'(PSUM_W) +: PSUM_W];
          end
        end
        count_d = count_d + CW'(PER_BEAT);
      end
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/ipsum_stream_buffer.sv
// Input-psum staging buffer: round-robin GLB beats into per-row FIFOs, lock-step drain.
module ipsum_stream_buffer #(
  parameter int unsigned ROWS   = aioc_pe_pkg::ROW_NUM,
  parameter int unsigned PSUM_W = aioc_pe_pkg::PSUM_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BUS_W  = aioc_pe_pkg::GLB_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_load,
  input  logic [$clog2(ROWS)-1:0] row_first,
  input  logic [$clog2(ROWS)-1:0] row_last,
  input  logic                    zero_mode,
  ipsum_stream_buffer_if.slave    bus
);

  localparam int unsigned PER_BEAT = BUS_W / PSUM_W;
  localparam int unsigned BEATS    = DEPTH / PER_BEAT;
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned BW       = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [RW-1:0]   cursor_q,    cursor_d;
  logic [BW-1:0]   beat_cnt_q,  beat_cnt_d;
  logic [RW-1:0]   row_first_q, row_first_d;
  logic [RW-1:0]   row_last_q,  row_last_d;
  logic            zero_mode_q, zero_mode_d;
  logic [ROWS-1:0] row_mask_q,  row_mask_d;

  logic [CW-1:0]     count_c [ROWS];
  logic [PSUM_W-1:0] head_c  [ROWS];
  logic              all_nonempty_c;
  logic              all_full_c;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              push_c;
  logic              pop_c;
  logic [ROWS*PSUM_W-1:0] out_data_c;

  // Occupancy summary over the active window
  always_comb begin
    all_nonempty_c = 1'b1;
    all_full_c     = 1'b1;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (row_mask_q[r]) begin
        if (count_c[r] == '0)          all_nonempty_c = 1'b0;
        if (count_c[r] != CW'(DEPTH))  all_full_c     = 1'b0;
      end
    end
  end

  // Handshakes; ready uses the pre-pop count of the cursor row only
  always_comb begin
    in_ready_c  = !reset && !cfg_load && !zero_mode_q &&
                  (count_c[cursor_q] <= CW'(DEPTH - PER_BEAT));
    out_valid_c = !reset && !cfg_load && bus.drain && (zero_mode_q || all_nonempty_c);
    push_c      = bus.in_valid && in_ready_c;
    pop_c       = out_valid_c && !zero_mode_q;
  end

  // Configuration latch and round-robin cursor advance
  always_comb begin
    cursor_d    = cursor_q;
    beat_cnt_d  = beat_cnt_q;
    row_first_d = row_first_q;
    row_last_d  = row_last_q;
    zero_mode_d = zero_mode_q;
    row_mask_d  = row_mask_q;
    if (cfg_load) begin
      row_first_d = row_first;
      row_last_d  = row_last;
      zero_mode_d = zero_mode;
      cursor_d    = row_first;
      beat_cnt_d  = '0;
      for (int r = 0; r < int'(ROWS); r++)
        row_mask_d[r] = (RW'(r) >= row_first) && (RW'(r) <= row_last);
    end else if (push_c) begin
      if (beat_cnt_q == BW'(BEATS - 1)) begin
        beat_cnt_d = '0;
        cursor_d   = (cursor_q == row_last_q) ? row_first_q : (cursor_q + RW'(1));
      end else begin
        beat_cnt_d = beat_cnt_q + BW'(1);
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_q    <= '0;
      beat_cnt_q  <= '0;
      row_first_q <= '0;
      row_last_q  <= '0;
      zero_mode_q <= 1'b0;
      row_mask_q  <= ROWS'(1);
    end else begin
      cursor_q    <= cursor_d;
      beat_cnt_q  <= beat_cnt_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      zero_mode_q <= zero_mode_d;
      row_mask_q  <= row_mask_d;
    end
  end

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    ipsum_row_fifo #(
      .DEPTH    (DEPTH),
      .PSUM_W   (PSUM_W),
      .PER_BEAT (PER_BEAT)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (cfg_load),
      .push      (push_c && (cursor_q == RW'(r))),
      .push_data (bus.in_data),
      .pop       (pop_c && row_mask_q[r]),
      .head      (head_c[r]),
      .count     (count_c[r])
    );
  end

  // Output mux: heads of active rows, zeros elsewhere and in zero mode
  always_comb begin
    out_data_c = '0;
    for (int r = 0; r < int'(ROWS); r++)
      out_data_c[r*PSUM_W +: PSUM_W] = (row_mask_q[r] && !zero_mode_q) ? head_c[r] : '0;
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = out_data_c;
  assign bus.out_row_mask = row_mask_q;
  assign bus.fill_done    = !zero_mode_q && all_full_c;

endmodule

// File: tb/tb_ipsum_stream_buffer.sv
// Directed bench for ipsum_stream_buffer (32 rows, 16-bit psums, depth 4, 32-bit beats).
module tb_ipsum_stream_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [4:0] row_first;
  logic [4:0] row_last;
  logic       zero_mode;

  int errors = 0;
  int checks = 0;

  logic [31:0] t2_beats [4];
  logic        t2_rdy   [4];
  logic [15:0] t2_pops  [4];

  always #5 clk = ~clk;

  ipsum_stream_buffer_if bus ();

  ipsum_stream_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .row_first (row_first),
    .row_last  (row_last),
    .zero_mode (zero_mode),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] od1(input int r, input logic [15:0] v);
    logic [511:0] e;
    e = '0;
    e[r*16 +: 16] = v;
    return e;
  endfunction

  function automatic logic [511:0] od4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    return od1(0, a) | od1(1, b) | od1(2, c) | od1(3, d);
  endfunction

  task automatic cfg(input logic [4:0] first, input logic [4:0] last, input logic zm);
    cfg_load  = 1'b1;
    row_first = first;
    row_last  = last;
    zero_mode = zm;
    #1;
    chk("cfg_in_ready", bus.in_ready, 0);
    cyc();
    cfg_load = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    chk("push_ready", bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    t2_beats = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    t2_rdy   = '{1'b1, 1'b1, 1'b0, 1'b0};
    t2_pops  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    reset = 1'b1; cfg_load = 1'b0; zero_mode = 1'b0; row_first = '0; row_last = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.drain = 1'b0;

    // Reset state
    cyc(); cyc();
    bus.in_valid = 1'b1; #1;
    chk("rst_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0; bus.drain = 1'b1; #1;
    chk("rst_out_valid", bus.out_valid, 0);
    bus.drain = 1'b0;
    reset = 1'b0; #1;
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_row_mask", bus.out_row_mask, 1);
    chk("rst_fill_done", bus.fill_done, 0);
    chk("post_rst_ready", bus.in_ready, 1);
    cyc();

    // T1: window 0..3, eight beats, four lock-step drains
    cfg(5'd0, 5'd3, 1'b0);
    for (int k = 0; k < 8; k++) push({16'(2*k + 1), 16'(2*k + 2)});
    #1;
    chk("t1_fill_done", bus.fill_done, 1);
    chk("t1_ready_full", bus.in_ready, 0);
    chk("t1_mask", bus.out_row_mask, 32'hF);
    bus.drain = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_out_valid", bus.out_valid, 1);
      chk("t1_out_data", bus.out_data, od4(16'(1 + k), 16'(5 + k), 16'(9 + k), 16'(13 + k)));
      cyc();
    end
    #1;
    chk("t1_empty_valid", bus.out_valid, 0);
    bus.drain = 1'b0;

    // T2: single-row window 2..2, in_valid held for four beats
    cfg(5'd2, 5'd2, 1'b0);
    #1;
    chk("t2_mask", bus.out_row_mask, 32'h4);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = t2_beats[k];
      #1;
      chk("t2_in_ready", bus.in_ready, t2_rdy[k]);
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("t2_fill_done", bus.fill_done, 1);
    bus.drain = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_out_valid", bus.out_valid, 1);
      chk("t2_out_data", bus.out_data, od1(2, t2_pops[k]));
      cyc();
    end
    bus.drain = 1'b0;

    // T3: window 0..1, row0 full, row1 empty while drain is held
    cfg(5'd0, 5'd1, 1'b0);
    push(32'h0A0A_0B0B);
    push(32'h0C0C_0D0D);
    bus.drain = 1'b1; #1;
    chk("t3_wait_valid", bus.out_valid, 0);
    cyc();
    bus.in_valid = 1'b1; bus.in_data = 32'hAAAA_BBBB; #1;
    chk("t3_row1_ready", bus.in_ready, 1);
    chk("t3_wait_valid2", bus.out_valid, 0);
    cyc();
    bus.in_valid = 1'b0; #1;
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_out_data", bus.out_data, od1(0, 16'h0A0A) | od1(1, 16'hAAAA));
    cyc();
    bus.drain = 1'b0;

    // T4: full row with simultaneous drain and push
    cfg(5'd5, 5'd5, 1'b0);
    push(32'h0101_0202);
    push(32'h0303_0404);
    #1;
    chk("t4_fill_done", bus.fill_done, 1);
    chk("t4_ready_full", bus.in_ready, 0);
    bus.drain = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h0505_0606;
    #1;
    chk("t4_ready_prepop4", bus.in_ready, 0);
    chk("t4_valid_a", bus.out_valid, 1);
    chk("t4_data_a", bus.out_data, od1(5, 16'h0101));
    cyc();
    #1;
    chk("t4_ready_prepop3", bus.in_ready, 0);
    chk("t4_data_b", bus.out_data, od1(5, 16'h0202));
    chk("t4_fill_b", bus.fill_done, 0);
    cyc();
    #1;
    chk("t4_ready_prepop2", bus.in_ready, 1);
    chk("t4_data_c", bus.out_data, od1(5, 16'h0303));
    cyc();
    bus.in_valid = 1'b0; #1;
    chk("t4_ready_cnt3", bus.in_ready, 0);
    chk("t4_fill_cnt3", bus.fill_done, 0);
    chk("t4_data_d", bus.out_data, od1(5, 16'h0404));
    cyc();
    #1;
    chk("t4_data_e", bus.out_data, od1(5, 16'h0505));
    cyc();
    #1;
    chk("t4_valid_f", bus.out_valid, 1);
    chk("t4_data_f", bus.out_data, od1(5, 16'h0606));
    cyc();
    #1;
    chk("t4_empty_valid", bus.out_valid, 0);
    bus.drain = 1'b0;

    // T5: zero mode drains zeros with no GLB traffic
    cfg(5'd0, 5'd3, 1'b1);
    bus.drain = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_out_valid", bus.out_valid, 1);
      chk("t5_out_data", bus.out_data, 0);
      chk("t5_in_ready", bus.in_ready, 0);
      chk("t5_fill_done", bus.fill_done, 0);
      cyc();
    end
    bus.drain = 1'b0; bus.in_valid = 1'b0;

    // T6a: cfg_load after three beats flushes everything
    cfg(5'd0, 5'd1, 1'b0);
    push(32'h1000_2000);
    push(32'h3000_4000);
    push(32'h5000_6000);
    cfg_load = 1'b1; row_first = 5'd1; row_last = 5'd1; bus.drain = 1'b1;
    #1;
    chk("t6_cfg_valid", bus.out_valid, 0);
    chk("t6_cfg_ready", bus.in_ready, 0);
    cyc();
    cfg_load = 1'b0; #1;
    chk("t6_flush_valid", bus.out_valid, 0);
    chk("t6_flush_data", bus.out_data, 0);
    chk("t6_mask", bus.out_row_mask, 32'h2);
    bus.drain = 1'b0;
    push(32'h7000_8000);
    bus.drain = 1'b1; #1;
    chk("t6_cursor_valid", bus.out_valid, 1);
    chk("t6_cursor_data", bus.out_data, od1(1, 16'h7000));
    cyc();
    bus.drain = 1'b0;
    push(32'h9000_A000);

    // T6b: reset mid-transfer discards all data
    reset = 1'b1; bus.drain = 1'b1; #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    cyc();
    reset = 1'b0; #1;
    chk("t6_rst_mask", bus.out_row_mask, 1);
    chk("t6_rst_valid2", bus.out_valid, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_fill", bus.fill_done, 0);
    bus.drain = 1'b0;
    push(32'hBEEF_CAFE);
    bus.drain = 1'b1; #1;
    chk("t6_post_rst_valid", bus.out_valid, 1);
    chk("t6_post_rst_data", bus.out_data, od1(0, 16'hBEEF));
    cyc();
    bus.drain = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
